// File: rtl/mm_pkg.sv
// Shared sizing, FSM state encoding and element addressing for the 4x4 matrix multiply engine.
package mm_pkg;

  localparam int unsigned DIM    = 4;
  localparam int unsigned ELEM_W = 16;
  localparam int unsigned MAT_W  = DIM * DIM * ELEM_W;
  localparam int unsigned ROW_W  = DIM * ELEM_W;
  localparam int unsigned IDX_W  = $clog2(DIM * DIM);
  localparam int unsigned SEL_W  = $clog2(DIM);
  localparam int unsigned OFF_W  = $clog2(MAT_W);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Bit offset of element (r,c) within a row-major packed matrix.
  function automatic logic [OFF_W-1:0] elem_off(input int unsigned r, input int unsigned c);
    return OFF_W'(ELEM_W * (DIM * r + c));
  endfunction

endpackage

// File: rtl/mm_dot4.sv
// Combinational dot product of one A row and one B column; products and sum wrap mod 2^ELEM_W.
module mm_dot4
  import mm_pkg::*;
(
  input  logic [ROW_W-1:0]  i_row,
  input  logic [ROW_W-1:0]  i_col,
  output logic [ELEM_W-1:0] o_dot_c
);

  localparam int unsigned PROD_W = 2 * ELEM_W;

  logic [PROD_W-1:0] w_prod;
  logic [ELEM_W-1:0] w_sum;

  // Only the low ELEM_W bits of each product contribute to the wrapped sum.
  always_comb begin
    w_prod = '0;
    w_sum  = '0;
    for (int k = 0; k < int'(DIM); k++) begin
      w_prod = PROD_W'(i_row[k*ELEM_W +: ELEM_W]) * PROD_W'(i_col[k*ELEM_W +: ELEM_W]);
      w_sum  = w_sum + w_prod[ELEM_W-1:0];
    end
  end

  assign o_dot_c = w_sum;

endmodule

// File: rtl/mat_mult_engine.sv
// 4x4 unsigned matrix multiply: latches A/B on start, produces one C element per cycle,
// then holds the full result until the consumer acknowledges it.
module mat_mult_engine
  import mm_pkg::*;
(
  input  logic             clk,
  input  logic             nReset,
  input  logic             start,
  input  logic [MAT_W-1:0] opA,
  input  logic [MAT_W-1:0] opB,
  output logic             busy,
  output logic             resValid,
  output logic [MAT_W-1:0] resData,
  input  logic             resAck
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [MAT_W-1:0]  r_a;
  logic [MAT_W-1:0]  r_b;
  logic [MAT_W-1:0]  r_acc;
  logic [MAT_W-1:0]  r_res;
  logic              r_busy;
  logic              r_res_valid;

  logic [SEL_W-1:0]  w_row_sel;
  logic [SEL_W-1:0]  w_col_sel;
  logic [ROW_W-1:0]  w_row;
  logic [ROW_W-1:0]  w_col;
  logic [ELEM_W-1:0] w_dot;
  logic              w_last;

  assign w_row_sel = r_idx[IDX_W-1 -: SEL_W];
  assign w_col_sel = r_idx[SEL_W-1:0];
  assign w_last    = (r_idx == IDX_W'(DIM * DIM - 1));

  // Row of A is contiguous; column of B is gathered element by element.
  always_comb begin
    w_row = r_a[elem_off(32'(w_row_sel), 0) +: ROW_W];
    w_col = '0;
    for (int k = 0; k < int'(DIM); k++) begin
      w_col[k*ELEM_W +: ELEM_W] = r_b[elem_off(k, 32'(w_col_sel)) +: ELEM_W];
    end
  end

  mm_dot4 u_dot (
    .i_row   (w_row),
    .i_col   (w_col),
    .o_dot_c (w_dot)
  );

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = COMPUTE;
      COMPUTE: if (w_last) w_state_nxt = DONE;
      DONE:    if (resAck) w_state_nxt = IDLE;
      default:             w_state_nxt = IDLE;
    endcase
  end

  // The last element bypasses the accumulator so the result lands on the same edge.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_res       <= '0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a    <= opA;
            r_b    <= opB;
            r_idx  <= '0;
            r_busy <= 1'b1;
          end
        end
        COMPUTE: begin
          r_acc[elem_off(32'(w_row_sel), 32'(w_col_sel)) +: ELEM_W] <= w_dot;
          r_idx <= r_idx + IDX_W'(1);
          if (w_last) begin
            r_res       <= {w_dot, r_acc[MAT_W-ELEM_W-1:0]};
            r_res_valid <= 1'b1;
          end
        end
        DONE: begin
          if (resAck) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_busy      <= 1'b0;
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign resValid = r_res_valid;
  assign resData  = r_res;

endmodule

// File: tb/tb_mat_mult_engine.sv
// Directed bench for mat_mult_engine with a result scoreboard and an independent C = A*B model.
module tb_mat_mult_engine;
  import mm_pkg::*;

  logic             clk = 1'b0;
  logic             nReset;
  logic             start;
  logic [MAT_W-1:0] opA;
  logic [MAT_W-1:0] opB;
  logic             busy;
  logic             resValid;
  logic [MAT_W-1:0] resData;
  logic             resAck;

  logic [MAT_W-1:0] sb[$];
  int               total = 0;
  int               bad   = 0;

  always #5 clk = ~clk;

  mat_mult_engine dut (
    .clk      (clk),
    .nReset   (nReset),
    .start    (start),
    .opA      (opA),
    .opB      (opB),
    .busy     (busy),
    .resValid (resValid),
    .resData  (resData),
    .resAck   (resAck)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [MAT_W-1:0] obs, input logic [MAT_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [MAT_W-1:0] model(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
    logic [MAT_W-1:0] c;
    int unsigned      s;
    c = '0;
    for (int r = 0; r < 4; r++) begin
      for (int col = 0; col < 4; col++) begin
        s = 0;
        for (int k = 0; k < 4; k++) begin
          s = s + 32'(a[16*(4*r+k) +: 16]) * 32'(b[16*(4*k+col) +: 16]);
        end
        c[16*(4*r+col) +: 16] = 16'(s);
      end
    end
    return c;
  endfunction

  // One full operation: start at E0, exact result check at E16, optional disturbances.
  task automatic run(input string tag, input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b,
                     input logic [MAT_W-1:0] exp_c, input int poke, input bit ack_start, input int hold);
    logic [MAT_W-1:0] got;
    opA   = a;
    opB   = b;
    start = 1'b1;
    sb.push_back(exp_c);
    tick();
    start = 1'b0;
    check({tag, "_busy_e0"}, MAT_W'(busy), MAT_W'(1));
    for (int i = 1; i <= 15; i++) begin
      if (i == poke) begin
        start  = 1'b1;
        resAck = 1'b1;
        opA    = ~a;
        opB    = ~b;
      end
      tick();
      start  = 1'b0;
      resAck = 1'b0;
    end
    check({tag, "_valid_e15"}, MAT_W'(resValid), MAT_W'(0));
    tick();
    check({tag, "_valid_e16"}, MAT_W'(resValid), MAT_W'(1));
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_scoreboard: observed=result expected=no result queued", tag);
      got = 'x;
    end else begin
      got = sb.pop_front();
      check({tag, "_data"}, resData, got);
    end
    for (int h = 0; h < hold; h++) begin
      opA = {8{$urandom()}};
      opB = {8{$urandom()}};
      tick();
      check({tag, "_hold_valid"}, MAT_W'(resValid), MAT_W'(1));
      check({tag, "_hold_data"}, resData, got);
    end
    check({tag, "_busy_pre_ack"}, MAT_W'(busy), MAT_W'(1));
    if (ack_start) begin
      start = 1'b1;
      opA   = {8{$urandom()}};
      opB   = {8{$urandom()}};
    end
    resAck = 1'b1;
    tick();
    resAck = 1'b0;
    start  = 1'b0;
    check({tag, "_busy_post_ack"}, MAT_W'(busy), MAT_W'(0));
    check({tag, "_valid_post_ack"}, MAT_W'(resValid), MAT_W'(0));
    if (ack_start) begin
      repeat (3) tick();
      check({tag, "_no_rerun_busy"}, MAT_W'(busy), MAT_W'(0));
      check({tag, "_no_rerun_data"}, resData, got);
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [MAT_W-1:0] ia;
    logic [MAT_W-1:0] seq;
    logic [MAT_W-1:0] ra;
    logic [MAT_W-1:0] rb;

    nReset = 1'b0;
    start  = 1'b0;
    resAck = 1'b0;
    opA    = '0;
    opB    = '0;
    #3;
    check("rst_busy", MAT_W'(busy), MAT_W'(0));
    check("rst_valid", MAT_W'(resValid), MAT_W'(0));
    check("rst_data", resData, '0);
    #9;
    nReset = 1'b1;
    tick();
    check("idle_busy", MAT_W'(busy), MAT_W'(0));

    ia  = '0;
    seq = '0;
    for (int i = 0; i < 4; i++) ia[16*(5*i) +: 16] = 16'h0001;
    for (int i = 0; i < 16; i++) seq[16*i +: 16] = 16'(i + 1);
    run("identity", ia, seq, seq, 0, 1'b0, 0);

    run("twos", {16{16'h0002}}, {16{16'h0002}}, {16{16'h0010}}, 0, 1'b0, 0);
    run("wrap", {16{16'hFFFF}}, {16{16'hFFFF}}, {16{16'h0004}}, 0, 1'b0, 0);

    ra = {8{$urandom()}};
    rb = {8{$urandom()}};
    run("ignored_start", ra, rb, model(ra, rb), 5, 1'b1, 0);

    ra = {8{$urandom()}};
    rb = {8{$urandom()}};
    run("hold_done", ra, rb, model(ra, rb), 0, 1'b0, 10);

    // Abort at idx=7 with a non-zero previous result still on resData.
    opA   = {8{$urandom()}};
    opB   = {8{$urandom()}};
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    #2;
    nReset = 1'b0;
    #1;
    check("abort_busy", MAT_W'(busy), MAT_W'(0));
    check("abort_valid", MAT_W'(resValid), MAT_W'(0));
    check("abort_data", resData, '0);
    @(negedge clk);
    nReset = 1'b1;
    repeat (20) tick();
    check("abort_no_valid", MAT_W'(resValid), MAT_W'(0));
    check("abort_idle_busy", MAT_W'(busy), MAT_W'(0));

    ra = {8{$urandom()}};
    rb = {8{$urandom()}};
    run("after_reset", ra, rb, model(ra, rb), 0, 1'b0, 0);

    check("sb_empty", MAT_W'(sb.size()), MAT_W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
